// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared types and constants for the ROB allocation controller.
// Optional feature macro: ROB_ALLOC_STATS_EN (occupancy/stall/flush counters).
package rob_alloc_ctrl_pkg;

    localparam int ROB_DEPTH       = 16;
    localparam int PTR_W           = 4;
    localparam int ROB_RECOVER_CYC = 2;

    typedef logic [PTR_W-1:0] robNumT;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } robAllocStateT;

    typedef struct packed {
        logic   grant1;
        logic   grant2;
        robNumT robNum1;
        robNumT robNum2;
    } robDispatchStruct;

    // Number of entries actually retired: never more than are occupied.
    function automatic logic [PTR_W:0] clamp_ret(input logic [1:0] ret, input logic [PTR_W:0] cnt);
        logic [PTR_W:0] r;
        r = (PTR_W+1)'(ret);
        return (r > cnt) ? cnt : r;
    endfunction

endpackage

// File: rtl/rob_alloc_ctrl_if.sv
// Dispatch / retire / status bundle between the pipeline and the ROB allocation controller.
interface rob_alloc_if;
    import rob_alloc_ctrl_pkg::*;

    logic             disp_req1;
    logic             disp_req2;
    logic [1:0]       retire_cnt;
    logic             flush;
    logic             grant1;
    logic             grant2;
    robNumT           rob_num1;
    robNumT           rob_num2;
    logic             stall;
    robNumT           head;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;

    // Pipeline side: requests, retires and flushes; observes grants and status.
    modport master (
        output disp_req1, disp_req2, retire_cnt, flush,
        input  grant1, grant2, rob_num1, rob_num2, stall, head, count, full, empty
    );

    // Controller side.
    modport slave (
        input  disp_req1, disp_req2, retire_cnt, flush,
        output grant1, grant2, rob_num1, rob_num2, stall, head, count, full, empty
    );
endinterface

// File: rtl/rob_alloc_ctrl_stats.sv
// Saturating 32-bit event counters for the ROB allocation controller
// (used only when ROB_ALLOC_STATS_EN is defined).
module rob_alloc_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        full,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] stat_full,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_flush
);
    logic flush_d;

    // Count full cycles, stall cycles and flush rising edges; hold at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_full  <= '0;
            stat_stall <= '0;
            stat_flush <= '0;
            flush_d    <= 1'b0;
        end else begin
            flush_d <= flush;
            if (full && stat_full != '1)
                stat_full <= stat_full + 32'd1;
            if (stall && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
            if (flush && !flush_d && stat_flush != '1)
                stat_flush <= stat_flush + 32'd1;
        end
    end
endmodule

// File: rtl/rob_alloc_ctrl.sv
// Head/tail/occupancy controller for the 16-entry ROB: in-order allocation of up
// to two slots per cycle, in-order retire of up to two, dispatch stall, and a
// timed RECOVER phase after a flush.
// Optional feature macro: ROB_ALLOC_STATS_EN adds stat_full/stat_stall/stat_flush.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int RECOVER_CYC = ROB_RECOVER_CYC
) (
    input  logic        clk,
    input  logic        reset,
    rob_alloc_if.slave  bus
`ifdef ROB_ALLOC_STATS_EN
    ,
    output logic [31:0] stat_full,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_flush
`endif
);
    localparam logic [0:0]     S_RUN     = RUN;
    localparam logic [0:0]     S_RECOVER = RECOVER;
    localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(ROB_DEPTH);
    localparam int             RC_W      = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RECOVER_CYC - 1);

    logic [0:0]       state_q;
    logic [RC_W-1:0]  rec_cnt_q;
    robNumT           head_q, tail_q, head_nxt;
    logic [PTR_W:0]   count_q, free, n_alloc, n_ret;
    logic             run, pair, g1, g2;
    robDispatchStruct disp;

    // Grants come from registered occupancy only; a pair is granted whole or not at all.
    always_comb begin
        run      = (state_q == S_RUN);
        pair     = bus.disp_req1 & bus.disp_req2;
        free     = DEPTH_C - count_q;
        g1       = run & ~bus.flush & bus.disp_req1 &
                   (pair ? (free >= (PTR_W+1)'(2)) : (free >= (PTR_W+1)'(1)));
        g2       = run & ~bus.flush & pair & (free >= (PTR_W+1)'(2));
        n_alloc  = (PTR_W+1)'(g1) + (PTR_W+1)'(g2);
        n_ret    = run ? clamp_ret(bus.retire_cnt, count_q) : '0;
        head_nxt = head_q + PTR_W'(n_ret);
        disp     = '{grant1: g1, grant2: g2, robNum1: tail_q, robNum2: tail_q + robNumT'(1)};
    end

    assign bus.grant1   = disp.grant1;
    assign bus.grant2   = disp.grant2;
    assign bus.rob_num1 = disp.robNum1;
    assign bus.rob_num2 = disp.robNum2;
    assign bus.stall    = ~run | (bus.disp_req1 & ~g1) | (pair & ~g2);
    assign bus.head     = head_q;
    assign bus.count    = count_q;
    assign bus.full     = (count_q == DEPTH_C);
    assign bus.empty    = (count_q == '0);

    // Pointer and occupancy update; a flush collapses the tail onto the post-retire head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q <= head_nxt;
            if (bus.flush) begin
                tail_q  <= head_nxt;
                count_q <= '0;
            end else begin
                tail_q  <= tail_q + PTR_W'(n_alloc);
                count_q <= count_q + n_alloc - n_ret;
            end
        end
    end

    // RUN/RECOVER sequencing; a flush (re)starts the RECOVER_CYC-cycle hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RUN;
            rec_cnt_q <= '0;
        end else if (bus.flush) begin
            state_q   <= S_RECOVER;
            rec_cnt_q <= '0;
        end else if (state_q == S_RECOVER) begin
            if (rec_cnt_q == RC_LAST) begin
                state_q   <= S_RUN;
                rec_cnt_q <= '0;
            end else begin
                rec_cnt_q <= rec_cnt_q + RC_W'(1);
            end
        end
    end

    // Protocol checks: younger request needs the older one; retire never exceeds occupancy.
    a_req2_needs_req1: assert property (@(posedge clk) disable iff (reset)
        bus.disp_req2 |-> bus.disp_req1);
    a_retire_le_count: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_RUN) |-> ((PTR_W+1)'(bus.retire_cnt) <= count_q));
    a_retire_le_two: assert property (@(posedge clk) disable iff (reset)
        bus.retire_cnt != 2'd3);

`ifdef ROB_ALLOC_STATS_EN
    rob_alloc_stats u_stats (
        .clk        (clk),
        .reset      (reset),
        .full       (bus.full),
        .stall      (bus.stall),
        .flush      (bus.flush),
        .stat_full  (stat_full),
        .stat_stall (stat_stall),
        .stat_flush (stat_flush)
    );
`endif

endmodule
